// File: rtl/act_relu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : act_relu_pipe
// Description : Two-stage valid/ready activation pipe (linear / ReLU / leaky /
//               clipped) with signed saturation to DATA_WIDTH per channel.
//               Optional saturation counter enabled by macro ACT_SAT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module act_relu_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int INT_WIDTH  = 4,
    parameter int NUM_CH     = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_mode,
    input  logic [DATA_WIDTH-1:0]          clip_max,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
    input  logic                           sat_clr,
    output logic [15:0]                    sat_count
);

    localparam int c_ACC_W = 2 * DATA_WIDTH;
    localparam int c_POP_W = $clog2(NUM_CH + 1);
    localparam int c_LO_W  = c_ACC_W - INT_WIDTH - DATA_WIDTH;

    localparam logic [1:0] c_MODE_LIN   = 2'b00;
    localparam logic [1:0] c_MODE_RELU  = 2'b01;
    localparam logic [1:0] c_MODE_LEAKY = 2'b10;
    localparam logic [1:0] c_MODE_CLIP  = 2'b11;

    localparam logic [DATA_WIDTH-1:0] c_MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                          w_s2_adv;
    logic                          w_s1_adv;
    logic                          w_s2_load;

    logic [NUM_CH*c_ACC_W-1:0]     w_val;
    logic [NUM_CH-1:0]             w_neg;
    logic [NUM_CH-1:0]             w_povf;
    logic [NUM_CH-1:0]             w_novf;
    logic [DATA_WIDTH-1:0]         w_cmax;

    logic                          r_s1_valid;
    logic [NUM_CH*c_ACC_W-1:0]     r_s1_val;
    logic [NUM_CH-1:0]             r_s1_neg;
    logic [NUM_CH-1:0]             r_s1_povf;
    logic [NUM_CH-1:0]             r_s1_novf;
    logic [1:0]                    r_s1_mode;
    logic [DATA_WIDTH-1:0]         r_s1_cmax;

    logic [NUM_CH*DATA_WIDTH-1:0]  w_res;
    logic [NUM_CH-1:0]             w_sat;
    logic [c_POP_W-1:0]            w_pop;

    logic                          r_out_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]  r_out_data;

    // in_ready depends only on out_ready and the stage valids, never on in_valid
    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_s2_load = w_s2_adv && r_s1_valid;
    assign in_ready  = w_s1_adv;

    assign w_cmax = clip_max[DATA_WIDTH-1] ? '0 : clip_max;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_s1_ch
        logic signed [c_ACC_W-1:0] w_x;
        logic signed [c_ACC_W-1:0] w_xs;
        logic [INT_WIDTH:0]        w_h;

        assign w_x  = in_data[c*c_ACC_W +: c_ACC_W];
        assign w_xs = (in_mode == c_MODE_LEAKY && w_x[c_ACC_W-1]) ? (w_x >>> LEAK_SHIFT) : w_x;
        assign w_h  = w_xs[c_ACC_W-1 -: INT_WIDTH+1];

        assign w_val[c*c_ACC_W +: c_ACC_W] = w_xs;
        assign w_neg[c]  = w_xs[c_ACC_W-1];
        assign w_povf[c] = !w_xs[c_ACC_W-1] && (w_h != '0);
        assign w_novf[c] = w_xs[c_ACC_W-1] && (w_h != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_neg   <= '0;
            r_s1_povf  <= '0;
            r_s1_novf  <= '0;
            r_s1_mode  <= c_MODE_LIN;
            r_s1_cmax  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_val  <= w_val;
                r_s1_neg  <= w_neg;
                r_s1_povf <= w_povf;
                r_s1_novf <= w_novf;
                r_s1_mode <= in_mode;
                r_s1_cmax <= w_cmax;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_s2_ch
        logic [DATA_WIDTH-1:0] w_slice;
        logic [DATA_WIDTH-1:0] w_lin;
        logic [DATA_WIDTH-1:0] w_relu;
        logic [DATA_WIDTH-1:0] w_r;
        logic                  w_lin_sat;
        logic                  w_relu_sat;
        logic                  w_r_sat;
        logic                  w_unused_bits;

        assign w_slice = r_s1_val[c*c_ACC_W + c_ACC_W - INT_WIDTH - 1 -: DATA_WIDTH];
        assign w_unused_bits = ^{r_s1_val[c*c_ACC_W +: c_LO_W],
                                 r_s1_val[(c+1)*c_ACC_W-1 -: INT_WIDTH]};

        always_comb begin
            w_lin     = w_slice;
            w_lin_sat = 1'b0;
            if (r_s1_povf[c]) begin
                w_lin     = c_MAX_POS;
                w_lin_sat = 1'b1;
            end else if (r_s1_novf[c]) begin
                w_lin     = c_MIN_NEG;
                w_lin_sat = 1'b1;
            end

            // zeroing a negative input is not a saturation event
            w_relu     = w_lin;
            w_relu_sat = w_lin_sat;
            if (r_s1_neg[c]) begin
                w_relu     = '0;
                w_relu_sat = 1'b0;
            end

            w_r     = w_lin;
            w_r_sat = w_lin_sat;
            case (r_s1_mode)
                c_MODE_RELU: begin
                    w_r     = w_relu;
                    w_r_sat = w_relu_sat;
                end
                c_MODE_CLIP: begin
                    // both operands are non-negative here, so unsigned compare is exact
                    if (w_relu > r_s1_cmax) begin
                        w_r     = r_s1_cmax;
                        w_r_sat = 1'b1;
                    end else begin
                        w_r     = w_relu;
                        w_r_sat = w_relu_sat;
                    end
                end
                default: begin
                    w_r     = w_lin;
                    w_r_sat = w_lin_sat;
                end
            endcase
        end

        assign w_res[c*DATA_WIDTH +: DATA_WIDTH] = w_r;
        assign w_sat[c] = w_r_sat;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + c_POP_W'(w_sat[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef ACT_SAT_CNT_EN
    logic [15:0] r_sat_count;
    logic [16:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_sat_count} + 17'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_s2_load) begin
            r_sat_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_cnt;

    assign w_unused_cnt = ^{1'b0, sat_clr, w_pop, w_s2_load};
    assign sat_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_relu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_relu_pipe
// Description : Directed self-checking bench for act_relu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_relu_pipe;

`ifdef ACT_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int SAT_BEATS = CNT_EN ? 16400 : 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [15:0]  clip_max;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         sat_clr;
    logic [15:0]  sat_count;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [15:0]  exp_cnt  = 16'd0;

    act_relu_pipe #(
        .DATA_WIDTH(16),
        .INT_WIDTH (4),
        .NUM_CH    (4),
        .LEAK_SHIFT(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .clip_max (clip_max),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_clr  (sat_clr),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat into an empty pipe; starts and ends 1 time unit after a clock edge.
    task automatic send_one(input string tag, input logic [1:0] mode, input logic [15:0] cm,
                            input logic [127:0] x, input logic [63:0] e, input int dsat);
        in_valid  = 1'b1;
        in_mode   = mode;
        clip_max  = cm;
        in_data   = x;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_mode  = 2'b00;
        clip_max = 16'h0000;
        in_data  = '0;
        check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        tick();
        exp_cnt = exp_cnt + (CNT_EN ? 16'(dsat) : 16'd0);
        check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"}, out_data, e);
        check({tag, "_cnt"}, {48'd0, sat_count}, {48'd0, exp_cnt});
        tick();
        check({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    int sent;
    int recv;
    int acc_cyc [8];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        clip_max  = 16'h0000;
        in_data   = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        tick();
        tick();
        check("rst_vld", {63'd0, out_valid}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_cnt", {48'd0, sat_count}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        tick();

        // Single-channel directed vectors on channel 0
        send_one("lin_slice", 2'b00, 16'h0000, {96'd0, 32'h0000_1000}, 64'h0001, 0);
        send_one("lin_pos",   2'b00, 16'h0000, {96'd0, 32'h0800_0000}, 64'h7FFF, 1);
        send_one("lin_neg",   2'b00, 16'h0000, {96'd0, 32'hFFF8_0000}, 64'hFF80, 0);
        send_one("lin_nsat",  2'b00, 16'h0000, {96'd0, 32'hF000_0000}, 64'h8000, 1);
        send_one("relu_neg",  2'b01, 16'h0000, {96'd0, 32'hFFF8_0000}, 64'h0000, 0);
        send_one("relu_pos",  2'b01, 16'h0000, {96'd0, 32'h0800_0000}, 64'h7FFF, 1);
        send_one("leaky_neg", 2'b10, 16'h0000, {96'd0, 32'hFFF8_0000}, 64'hFFF0, 0);
        send_one("leaky_sat", 2'b10, 16'h0000, {96'd0, 32'h8000_0000}, 64'h8000, 1);
        send_one("leaky_pos", 2'b10, 16'h0000, {96'd0, 32'h0000_1000}, 64'h0001, 0);
        send_one("clip_hit",  2'b11, 16'h1000, {96'd0, 32'h0200_0000}, 64'h1000, 1);
        send_one("clip_negc", 2'b11, 16'h8000, {96'd0, 32'h0000_1000}, 64'h0000, 1);
        send_one("clip_eq",   2'b11, 16'h1000, {96'd0, 32'h0100_0000}, 64'h1000, 0);
        send_one("clip_neg",  2'b11, 16'h1000, {96'd0, 32'hFFF8_0000}, 64'h0000, 0);
        send_one("clip_ovf",  2'b11, 16'h7FFF, {96'd0, 32'h0800_0000}, 64'h7FFF, 1);
        send_one("multi_ch",  2'b00, 16'h0000,
                 {32'hFFF8_0000, 32'hF000_0000, 32'h0800_0000, 32'h0000_1000},
                 {16'hFF80, 16'h8000, 16'h7FFF, 16'h0001}, 2);

        // Backpressure: out_ready low during cycles 3..6 of an 8-beat stream
        sent = 0;
        recv = 0;
        for (int k = 0; k < 40 && recv < 8; k++) begin
            out_ready = !(k >= 3 && k <= 6);
            in_valid  = (sent < 8);
            in_mode   = 2'b00;
            in_data   = (sent < 8) ? {96'd0, 32'(sent + 1) << 12} : '0;
            #1;
            if (k >= 3 && k <= 6) begin
                check("bp_stall_rdy", {63'd0, in_ready}, 64'd0);
                check("bp_hold_vld", {63'd0, out_valid}, 64'd1);
                check("bp_hold_data", out_data, 64'(recv + 1));
            end
            if (out_valid && out_ready) begin
                if (recv >= 8) begin
                    check("bp_extra", 64'(recv), 64'd7);
                end else begin
                    check("bp_order", out_data, 64'(recv + 1));
                    if (acc_cyc[recv] >= 7 || acc_cyc[recv] == 0) begin
                        check("bp_lat", 64'(k - acc_cyc[recv]), 64'd2);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready && sent < 8) begin
                acc_cyc[sent] = k;
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(recv), 64'd8);
        check("bp_cnt", {48'd0, sat_count}, {48'd0, exp_cnt});
        tick();
        tick();

        // Counter saturation and clear-with-event
        in_mode  = 2'b00;
        in_data  = {4{32'h0800_0000}};
        in_valid = 1'b1;
        for (int i = 0; i < SAT_BEATS; i++) begin
            tick();
        end
        check("cnt_stick", {48'd0, sat_count}, CNT_EN ? 64'hFFFF : 64'h0);
        sat_clr = 1'b1;
        tick();
        check("cnt_clr", {48'd0, sat_count}, 64'h0);
        sat_clr  = 1'b0;
        in_valid = 1'b0;
        tick();
        check("cnt_after_clr", {48'd0, sat_count}, CNT_EN ? 64'h4 : 64'h0);
        tick();
        check("cnt_idle", {48'd0, sat_count}, CNT_EN ? 64'h4 : 64'h0);
        tick();

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {96'd0, 32'h0800_0000};
        tick();
        tick();
        in_valid = 1'b0;
        check("rmid_vld", {63'd0, out_valid}, 64'd1);
        check("rmid_rdy", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        tick();
        check("rmid_out_vld", {63'd0, out_valid}, 64'd0);
        check("rmid_out_data", out_data, 64'd0);
        check("rmid_cnt", {48'd0, sat_count}, 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rmid_stale", {63'd0, out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_relu_pipe.md
# act_relu_pipe

Multi-channel, multi-mode activation stage placed between a layer's MAC accumulators and the next layer's input buffer. It takes NUM_CH double-width signed accumulator results, applies a per-beat selectable activation (linear, ReLU, leaky ReLU or clipped ReLU), and rescales each result to DATA_WIDTH with correct signed saturation. A 2-stage valid/ready pipeline with full backpressure replaces the old single-cycle, always-accept activation.

## Interface
- DATA_WIDTH, 16: output sample width; the input is 2*DATA_WIDTH per channel.
- INT_WIDTH, 4: extra integer bits in the input product format; the output slice is x[2*DATA_WIDTH-INT_WIDTH-1 -: DATA_WIDTH].
- NUM_CH, 4: channels processed in parallel per beat.
- LEAK_SHIFT, 3: arithmetic right shift applied to negative inputs in leaky mode, giving a slope of 2^-LEAK_SHIFT.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  2  activation: 00 linear, 01 ReLU, 10 leaky, 11 clipped. Captured with the beat.
- clip_max  in  DATA_WIDTH  clip ceiling for mode 11, signed; sampled with the beat.
- in_data  in  NUM_CH*2*DATA_WIDTH  channel c is in_data[c*2*DATA_WIDTH +: 2*DATA_WIDTH], signed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CH*DATA_WIDTH  channel c is out_data[c*DATA_WIDTH +: DATA_WIDTH], signed.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  16  count of saturated channel results.

## Operation
- Per channel, with W=DATA_WIDTH, I=INT_WIDTH and H = x[2W-1 : 2W-I-1] (I+1 bits):
  - Linear: if x ≥ 0 and H is nonzero, output 0x7FFF (max positive). If x < 0 and H is not all ones, output 0x8000 (min negative). Otherwise output the slice.
  - ReLU: if x < 0, output 0. Otherwise apply the linear positive rule.
  - Leaky: if x ≥ 0, apply the linear rule. If x < 0, set x' = x >>> LEAK_SHIFT at full 2W width, then apply the linear negative rule to x'.
  - Clipped: compute r = ReLU(x), then output min(r, cmax), where cmax = clip_max if clip_max ≥ 0, else 0.
- Stage 1 registers the beat:
  - the leaky-shifted or raw value per channel;
  - the sign and H overflow flags;
  - the mode and cmax.
- Stage 2 performs saturation, slicing and clipping. It registers out_data and out_valid.
- A channel counts as saturated when its output is forced to 0x7FFF, 0x8000 or cmax by overflow or clipping. ReLU zeroing of a negative input does not count.
- Each stage-2 load adds the number of saturated channels in that beat to sat_count.
- sat_count sticks at 0xFFFF instead of wrapping.
- sat_clr has priority over increment in the same cycle, and that cycle's increment is dropped.

## Timing
- Reset values: out_valid=0, out_data=0, sat_count=0, both stage valid bits 0. in_ready=1 in the first cycle after reset.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready=1 throughout.
- Throughput: 1 beat/cycle when out_ready=1.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready and the stage valids, with no path from in_valid.
- While out_valid && !out_ready, out_data is held stable. The pipe holds 2 beats and then deasserts in_ready. No beat is lost or duplicated.
- A bubble (in_valid=0) propagates as an invalid stage. It never stalls upstream.
- Reset mid-operation discards both in-flight beats. Output returns to reset values on the next edge.
- sat_count updates on the same edge that loads stage 2.

## Configuration
- ACT_SAT_CNT_EN: when defined, the saturation counter is implemented as above.
- When ACT_SAT_CNT_EN is undefined, the counter logic is removed. sat_count is tied to 0 and sat_clr is ignored. The port list is unchanged and datapath behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=16, INT_WIDTH=4, LEAK_SHIFT=3 and show channel 0.
- Linear slice and saturation:
  - x=0x0000_1000 → 0x0001.
  - x=0x0800_0000 → 0x7FFF, sat_count +1.
  - x=0xFFF8_0000 → 0xFF80.
  - x=0xF000_0000 → 0x8000, sat_count +1.
- Modes on x=0xFFF8_0000: ReLU → 0x0000 with no count; leaky → 0xFFF0.
- Clipped mode:
  - clip_max=0x1000, x=0x0200_0000 → 0x1000, sat_count +1.
  - clip_max=0x8000 (negative), x=0x0000_1000 → 0x0000.
- Backpressure:
  - Stream 8 beats with out_ready low for cycles 3–6 → in_ready drops after 2 beats are held.
  - out_data is stable while stalled.
  - All 8 beats emerge in order, with 2-cycle latency when unstalled.
- Reset mid-stream with 2 beats in flight → out_valid=0 and sat_count=0 next cycle; no stale beat appears afterward.
- Counter saturation:
  - Force 0xFFFF+ saturating events → sat_count holds 0xFFFF.
  - sat_clr asserted together with an event → 0.
  - With ACT_SAT_CNT_EN undefined, sat_count stays 0.
